// File: rtl/mdac_mix_seq_if.sv
// Handshake/data bundle for the time-multiplexed gain mixer.
// Master drives start, samples, gains and mutes; slave returns busy/valid and the mixed result.
interface mdac_mix_seq_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SIG_W    = 16,
  parameter int unsigned GAIN_W   = 8,
  parameter int unsigned OUT_W    = 16
);
  logic                       iStart;
  logic [CHANNELS*SIG_W-1:0]  iSignals;
  logic [CHANNELS*GAIN_W-1:0] iGains;
  logic [CHANNELS-1:0]        iMute;
  logic                       oBusy;
  logic                       oValid;
  logic [OUT_W-1:0]           oOut;
  logic                       oClip;

  modport master (
    output iStart, iSignals, iGains, iMute,
    input  oBusy, oValid, oOut, oClip
  );

  modport slave (
    input  iStart, iSignals, iGains, iMute,
    output oBusy, oValid, oOut, oClip
  );
endinterface

// File: rtl/mdac_mix_seq.sv
// Shared-MAC mixer: scales each snapshotted channel by its gain, one product per cycle,
// accumulates, then rounds, shifts and saturates into a single signed output sample.
module mdac_mix_seq #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SIG_W    = 16,
  parameter int unsigned GAIN_W   = 8,
  parameter int unsigned SHIFT    = 8,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned ROUND    = 1
) (
  input logic           clk,
  input logic           rst_n,
  mdac_mix_seq_if.slave bus
);

  localparam int unsigned PROD_W  = SIG_W + GAIN_W + 1;
  localparam int unsigned ACC_W   = PROD_W + $clog2(CHANNELS);
  localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SUM_W   = ACC_W + 1;
  localparam int unsigned CMP_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [SUM_W-1:0] RND_ADD =
      (ROUND != 0 && SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
  localparam logic signed [CMP_W-1:0] OUT_MAX = CMP_W'({(OUT_W - 1){1'b1}});
  localparam logic signed [CMP_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDrain, StOut} state_e;

  state_e                     state_q;
  logic signed [SIG_W-1:0]    sig_q  [CHANNELS];
  logic        [GAIN_W-1:0]   gain_q [CHANNELS];
  logic        [CHANNELS-1:0] mute_q;
  logic        [IDX_W-1:0]    idx_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       busy_q;
  logic                       valid_q;
  logic        [OUT_W-1:0]    out_q;
  logic                       clip_q;

  logic signed [PROD_W-1:0] sig_ext, gain_ext, prod_d;
  logic signed [SUM_W-1:0]  sum, shifted;
  logic signed [CMP_W-1:0]  ext;
  logic        [OUT_W-1:0]  sat_out;
  logic                     sat_clip;

  // Gain is zero-extended so the signed multiply treats it as unsigned.
  always_comb begin
    sig_ext  = {{(GAIN_W + 1){sig_q[idx_q][SIG_W-1]}}, sig_q[idx_q]};
    gain_ext = {{(SIG_W + 1){1'b0}}, gain_q[idx_q]};
    prod_d   = mute_q[idx_q] ? '0 : sig_ext * gain_ext;
  end

  always_comb begin
    sum      = $signed(SUM_W'(acc_q)) + $signed(RND_ADD);
    shifted  = sum >>> SHIFT;
    ext      = CMP_W'(shifted);
    sat_out  = ext[OUT_W-1:0];
    sat_clip = 1'b0;
    if (ext > OUT_MAX) begin
      sat_out  = OUT_MAX[OUT_W-1:0];
      sat_clip = 1'b1;
    end else if (ext < OUT_MIN) begin
      sat_out  = OUT_MIN[OUT_W-1:0];
      sat_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        sig_q[k]  <= '0;
        gain_q[k] <= '0;
      end
      mute_q  <= '0;
      idx_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
              sig_q[k]  <= bus.iSignals[k*SIG_W +: SIG_W];
              gain_q[k] <= bus.iGains[k*GAIN_W +: GAIN_W];
            end
            mute_q  <= bus.iMute;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StMul;
          end
        end
        StMul: begin
          prod_q <= prod_d;
          // The product register lags one cycle, so nothing is valid on the first issue.
          if (idx_q != '0) acc_q <= acc_q + ACC_W'(prod_q);
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_q <= StDrain;
        end
        StDrain: begin
          acc_q   <= acc_q + ACC_W'(prod_q);
          state_q <= StOut;
        end
        StOut: begin
          out_q   <= sat_out;
          clip_q  <= sat_clip;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oBusy  = busy_q;
  assign bus.oValid = valid_q;
  assign bus.oOut   = out_q;
  assign bus.oClip  = clip_q;

endmodule

// File: tb/tb_mdac_mix_seq.sv
// Randomised bench for mdac_mix_seq: a rounding and a truncating instance run the same
// stimulus and are compared against a plain-integer mix model.
module tb_mdac_mix_seq;
  localparam int C = 3;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdac_mix_seq_if #(.CHANNELS(C), .SIG_W(16), .GAIN_W(8), .OUT_W(16)) bus_r ();
  mdac_mix_seq_if #(.CHANNELS(C), .SIG_W(16), .GAIN_W(8), .OUT_W(16)) bus_t ();

  mdac_mix_seq #(.CHANNELS(C), .SIG_W(16), .GAIN_W(8), .SHIFT(SH), .OUT_W(16), .ROUND(1))
    u_dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  mdac_mix_seq #(.CHANNELS(C), .SIG_W(16), .GAIN_W(8), .SHIFT(SH), .OUT_W(16), .ROUND(0))
    u_dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  int tests_run = 0;
  int tests_failed = 0;
  int sig_v[C];
  int gain_v[C];
  logic [C-1:0] mute_v;
  logic start_v;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < C; k++) begin
      bus_r.iSignals[k*16 +: 16] = 16'(sig_v[k]);
      bus_t.iSignals[k*16 +: 16] = 16'(sig_v[k]);
      bus_r.iGains[k*8 +: 8]     = 8'(gain_v[k]);
      bus_t.iGains[k*8 +: 8]     = 8'(gain_v[k]);
    end
    bus_r.iMute  = mute_v;
    bus_t.iMute  = mute_v;
    bus_r.iStart = start_v;
    bus_t.iStart = start_v;
  endtask

  // Sum of unmuted sample*gain, optional half-LSB round, arithmetic shift, clamp to 16 bits.
  function automatic void model(input bit rnd, output longint o, output longint c);
    longint acc = 0;
    for (int k = 0; k < C; k++)
      if (!mute_v[k]) acc += longint'(sig_v[k]) * longint'(gain_v[k]);
    if (rnd) acc += longint'(1) << (SH - 1);
    acc = acc >>> SH;
    c = 0;
    o = acc;
    if (acc > 32767) begin o = 32767; c = 1; end
    else if (acc < -32768) begin o = -32768; c = 1; end
  endfunction

  task automatic rand_inputs();
    for (int k = 0; k < C; k++) begin
      if ($urandom_range(0, 1) == 1) sig_v[k] = int'($urandom_range(0, 6000)) - 3000;
      else sig_v[k] = int'($signed(16'($urandom)));
      gain_v[k] = int'($urandom_range(0, 255));
    end
    mute_v = 3'($urandom);
  endtask

  task automatic check_results(input string tag, input longint er, input longint cr,
                               input longint et, input longint ct);
    check({tag, " out_r"},  longint'($signed(bus_r.oOut)), er);
    check({tag, " clip_r"}, longint'(bus_r.oClip), cr);
    check({tag, " out_t"},  longint'($signed(bus_t.oOut)), et);
    check({tag, " clip_t"}, longint'(bus_t.oClip), ct);
  endtask

  // One mix: start at E0, optionally scramble inputs afterwards, expect oValid after E5.
  task automatic run_mix(input string tag, input bit scramble);
    longint er, cr, et, ct;
    int lat;
    model(1'b1, er, cr);
    model(1'b0, et, ct);
    @(negedge clk);
    start_v = 1'b1;
    apply();
    @(posedge clk);
    #1;
    check({tag, " busy@E0"}, longint'(bus_r.oBusy), 1);
    @(negedge clk);
    start_v = 1'b0;
    if (scramble) rand_inputs();
    apply();
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus_r.oValid) begin
        lat = k;
        break;
      end
      if (k < 5 && !bus_r.oBusy) check({tag, " busy mid"}, 0, 1);
    end
    check({tag, " latency"}, longint'(lat), 5);
    check({tag, " valid_t"}, longint'(bus_t.oValid), 1);
    check({tag, " busy done"}, longint'(bus_r.oBusy), 0);
    check_results(tag, er, cr, et, ct);
    @(posedge clk);
    #1;
    check({tag, " valid pulse"}, longint'(bus_r.oValid), 0);
  endtask

  initial begin
    int pulses[$];
    longint er, cr, et, ct;
    int vcount;
    start_v = 1'b0;
    sig_v = '{0, 0, 0};
    gain_v = '{0, 0, 0};
    mute_v = '0;
    apply();

    // Reset held with start toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_v = i[0];
      apply();
      @(posedge clk);
      #1;
      if (bus_r.oBusy || bus_r.oValid || bus_r.oOut != 0 || bus_r.oClip || bus_t.oBusy)
        check("reset hold", 1, 0);
    end
    check("reset busy", longint'(bus_r.oBusy), 0);
    check("reset out", longint'(bus_r.oOut), 0);
    @(negedge clk);
    start_v = 1'b0;
    apply();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle busy", longint'(bus_r.oBusy), 0);
    check("idle valid", longint'(bus_r.oValid), 0);

    sig_v = '{1000, 2000, -500};
    gain_v = '{255, 128, 0};
    mute_v = 3'b000;
    run_mix("basic", 1'b0);

    sig_v = '{1000, 2000, -500};
    gain_v = '{255, 128, 0};
    mute_v = 3'b001;
    run_mix("mute snap", 1'b1);

    sig_v = '{32767, 32767, 32767};
    gain_v = '{255, 255, 255};
    mute_v = 3'b000;
    run_mix("sat pos", 1'b0);
    sig_v = '{-32768, -32768, -32768};
    run_mix("sat neg", 1'b0);

    sig_v = '{-1, 0, 0};
    gain_v = '{128, 0, 0};
    mute_v = 3'b110;
    run_mix("rnd 128", 1'b0);
    gain_v = '{129, 0, 0};
    run_mix("rnd 129", 1'b0);

    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      run_mix("random", i[0]);
    end

    // Start held high: one result every C+3 cycles, extra starts ignored
    rand_inputs();
    model(1'b1, er, cr);
    model(1'b0, et, ct);
    @(negedge clk);
    start_v = 1'b1;
    apply();
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      if (bus_r.oValid) begin
        pulses.push_back(i);
        check_results("held", er, cr, et, ct);
      end
    end
    @(negedge clk);
    start_v = 1'b0;
    apply();
    check("held pulses", longint'(pulses.size()), 6);
    for (int i = 1; i < pulses.size(); i++)
      check("held period", longint'(pulses[i] - pulses[i-1]), 6);
    repeat (10) @(posedge clk);

    // Abort by reset at E2
    rand_inputs();
    @(negedge clk);
    start_v = 1'b1;
    apply();
    @(posedge clk);
    @(negedge clk);
    start_v = 1'b0;
    apply();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", longint'(bus_r.oBusy), 0);
    check("abort busy_t", longint'(bus_t.oBusy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus_r.oValid || bus_t.oValid) vcount++;
    end
    check("abort no valid", longint'(vcount), 0);
    rand_inputs();
    run_mix("after abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
